// File: rtl/maxpool3x3_s2_fp32_if.sv
// rtl/maxpool3x3_s2_fp32_if.sv - pixel stream in / pooled stream out bundle for maxpool3x3_s2_fp32
interface maxpool3x3_s2_fp32_if #(
  parameter int data_width = 32
);
  logic                  valid_in;
  logic [data_width-1:0] pxl_in;
  logic [data_width-1:0] pxl_out;
  logic                  valid_out;
  logic                  frame_done;

  modport master (
    output valid_in, pxl_in,
    input  pxl_out, valid_out, frame_done
  );

  modport slave (
    input  valid_in, pxl_in,
    output pxl_out, valid_out, frame_done
  );
endinterface

// File: rtl/maxpool3x3_s2_fp32.sv
// rtl/maxpool3x3_s2_fp32.sv - streaming 3x3 stride-2 valid max-pool over a D x D fp32 channel
// Optional macro RELU_EN clamps negative pooled results (including -0) to +0.
module maxpool3x3_s2_fp32 #(
  parameter int data_width = 32,
  parameter int D          = 35
) (
  input logic                   clk,
  input logic                   reset,
  maxpool3x3_s2_fp32_if.slave   s
);

  localparam int            CW     = $clog2(D);
  localparam logic [CW-1:0] LAST   = CW'(D - 1);
  localparam logic [CW-1:0] ANCHOR = CW'(((D - 3) / 2) * 2 + 2);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_col;
  logic [CW-1:0]         r_row;
  logic [data_width-1:0] r_lb0 [D];
  logic [data_width-1:0] r_lb1 [D];
  logic [data_width-1:0] r_win [3][3];
  logic                  r_win_vld;
  logic                  r_win_last;
  logic [data_width-1:0] r_s1 [3];
  logic                  r_s1_vld;
  logic                  r_s1_last;
  logic [data_width-1:0] r_pxl_out;
  logic                  r_valid_out;
  logic                  r_frame_done;

  logic                  w_row_end;
  logic                  w_frame_end;
  logic                  w_anchor;
  logic                  w_anchor_last;
  logic [data_width-1:0] w_pool;
  logic [data_width-1:0] w_pool_out;

  // Signed-magnitude ordering on raw bits; +0 and -0 are equal so ties keep the earlier operand.
  function automatic logic gt(input logic [data_width-1:0] a, input logic [data_width-1:0] b);
    logic res;
    if (a[data_width-2:0] == '0 && b[data_width-2:0] == '0)
      res = 1'b0;
    else if (a[data_width-1] != b[data_width-1])
      res = ~a[data_width-1];
    else if (!a[data_width-1])
      res = a[data_width-2:0] > b[data_width-2:0];
    else
      res = a[data_width-2:0] < b[data_width-2:0];
    return res;
  endfunction

  function automatic logic [data_width-1:0] max2(input logic [data_width-1:0] a,
                                                 input logic [data_width-1:0] b);
    return gt(b, a) ? b : a;
  endfunction

  function automatic logic [data_width-1:0] max3(input logic [data_width-1:0] a,
                                                 input logic [data_width-1:0] b,
                                                 input logic [data_width-1:0] c);
    return max2(max2(a, b), c);
  endfunction

  assign w_row_end     = (r_col == LAST);
  assign w_frame_end   = w_row_end && (r_row == LAST);
  assign w_anchor      = s.valid_in && (r_state == RUN) &&
                         (r_row >= CW'(2)) && (r_col >= CW'(2)) && !r_row[0] && !r_col[0];
  assign w_anchor_last = w_anchor && (r_row == ANCHOR) && (r_col == ANCHOR);

  assign w_pool = max3(r_s1[0], r_s1[1], r_s1[2]);

`ifdef RELU_EN
  assign w_pool_out = w_pool[data_width-1] ? '0 : w_pool;
`else
  assign w_pool_out = w_pool;
`endif

  // Control: FSM, raster counters and the valid/last pipeline that tracks window data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_win_vld    <= 1'b0;
      r_win_last   <= 1'b0;
      r_s1_vld     <= 1'b0;
      r_s1_last    <= 1'b0;
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
      r_pxl_out    <= '0;
    end else begin
      r_win_vld    <= w_anchor;
      r_win_last   <= w_anchor_last;
      r_s1_vld     <= r_win_vld;
      r_s1_last    <= r_win_last;
      r_valid_out  <= r_s1_vld;
      r_frame_done <= r_s1_last;
      if (r_s1_vld)
        r_pxl_out <= w_pool_out;

      if (s.valid_in) begin
        if (w_row_end) begin
          r_col <= '0;
          r_row <= w_frame_end ? '0 : r_row + CW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end

        case (r_state)
          IDLE:    r_state <= FILL;
          FILL:    if (w_row_end && r_row == CW'(1)) r_state <= RUN;
          RUN:     if (w_frame_end) r_state <= FILL;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Datapath: line buffers and window shift on accepted pixels; row maxima every cycle.
  always_ff @(posedge clk) begin
    if (s.valid_in) begin
      r_lb1[r_col] <= r_lb0[r_col];
      r_lb0[r_col] <= s.pxl_in;
      for (int i = 0; i < 3; i++) begin
        r_win[i][0] <= r_win[i][1];
        r_win[i][1] <= r_win[i][2];
      end
      r_win[0][2] <= r_lb1[r_col];
      r_win[1][2] <= r_lb0[r_col];
      r_win[2][2] <= s.pxl_in;
    end
    for (int i = 0; i < 3; i++)
      r_s1[i] <= max3(r_win[i][0], r_win[i][1], r_win[i][2]);
  end

  assign s.pxl_out    = r_pxl_out;
  assign s.valid_out  = r_valid_out;
  assign s.frame_done = r_frame_done;

endmodule

// File: tb/tb_maxpool3x3_s2_fp32.sv
// tb/tb_maxpool3x3_s2_fp32.sv - directed and random checks of maxpool3x3_s2_fp32 at D=5 and D=35
module tb_maxpool3x3_s2_fp32;

  typedef struct {
    logic [31:0] v;
    logic        last;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  maxpool3x3_s2_fp32_if #(.data_width(32)) if5 ();
  maxpool3x3_s2_fp32_if #(.data_width(32)) if35 ();

  maxpool3x3_s2_fp32 #(.data_width(32), .D(5))  dut5  (.clk(clk), .reset(reset), .s(if5.slave));
  maxpool3x3_s2_fp32 #(.data_width(32), .D(35)) dut35 (.clk(clk), .reset(reset), .s(if35.slave));

  logic [31:0] img [2][35][35];
  int          mr [2];
  int          mc [2];
  exp_t        q5 [$];
  exp_t        q35 [$];
  logic [31:0] obs5 [$];
  logic [31:0] obs35 [$];
  int          strobes [2];
  int          fdones [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] f2b(input int k);
    int e;
    if (k == 0) return 32'h0;
    e = $clog2(k + 1) - 1;
    return {1'b0, 8'(e + 127), 23'((k << (23 - e)) & 32'h7FFFFF)};
  endfunction

  // Total order used by the pool: magnitude, negated when the sign bit is set.
  function automatic longint key(input logic [31:0] b);
    longint m;
    m = longint'(b[30:0]);
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] relu(input logic [31:0] b);
`ifdef RELU_EN
    return b[31] ? 32'h0 : b;
`else
    return b;
`endif
  endfunction

  task automatic model_accept(input int k, input logic [31:0] px, input int scyc);
    int d, r, c, la;
    logic [31:0] best;
    exp_t e;
    d  = (k == 0) ? 5 : 35;
    la = ((d - 3) / 2) * 2 + 2;
    r  = mr[k];
    c  = mc[k];
    img[k][r][c] = px;
    if (r >= 2 && c >= 2 && r % 2 == 0 && c % 2 == 0) begin
      best = img[k][r-2][c-2];
      for (int i = r - 2; i <= r; i++)
        for (int j = c - 2; j <= c; j++)
          if (key(img[k][i][j]) > key(best)) best = img[k][i][j];
      e.v    = relu(best);
      e.last = (r == la && c == la);
      e.cyc  = scyc + 2;
      if (k == 0) q5.push_back(e);
      else        q35.push_back(e);
    end
    mc[k] = c + 1;
    if (mc[k] == d) begin
      mc[k] = 0;
      mr[k] = (r + 1 == d) ? 0 : r + 1;
    end
  endtask

  task automatic send(input int k, input logic [31:0] px);
    @(negedge clk);
    if5.valid_in  = (k == 0);
    if35.valid_in = (k == 1);
    if (k == 0) if5.pxl_in = px;
    else        if35.pxl_in = px;
    model_accept(k, px, cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      if5.valid_in  = 1'b0;
      if35.valid_in = 1'b0;
    end
  endtask

  task automatic clear_obs();
    obs5.delete();
    obs35.delete();
    strobes = '{0, 0};
    fdones  = '{0, 0};
  endtask

  task automatic mon(input int k, input logic v, input logic fd, input logic [31:0] px);
    exp_t e;
    if (v === 1'b1) begin
      strobes[k]++;
      if (fd === 1'b1) fdones[k]++;
      if (k == 0) obs5.push_back(px);
      else        obs35.push_back(px);
      if ((k == 0 && q5.size() == 0) || (k == 1 && q35.size() == 0)) begin
        n_chk++;
        $error("FAIL unexpected_valid_out d%0d: observed pxl %h at cycle %0d expected no strobe", k, px, cyc);
      end else begin
        e = (k == 0) ? q5.pop_front() : q35.pop_front();
        check($sformatf("pxl_out d%0d", k), px, e.v);
        check($sformatf("frame_done d%0d", k), 32'(fd), 32'(e.last));
        check($sformatf("latency d%0d", k), 32'(cyc), 32'(e.cyc));
      end
    end else if (fd !== 1'b0) begin
      n_chk++;
      $error("FAIL stray_frame_done d%0d: observed %b expected 0", k, fd);
    end
  endtask

  always @(negedge clk) begin
    mon(0, if5.valid_out, if5.frame_done, if5.pxl_out);
    mon(1, if35.valid_out, if35.frame_done, if35.pxl_out);
  end

  initial begin
    logic [31:0] t1 [4];
    logic [31:0] px;
    logic [31:0] z00;
    t1 = '{32'h41400000, 32'h41600000, 32'h41B00000, 32'h41C00000};
    mr = '{0, 0};
    mc = '{0, 0};
    if5.valid_in  = 1'b0;
    if5.pxl_in    = '0;
    if35.valid_in = 1'b0;
    if35.pxl_in   = '0;
    clear_obs();

    // Reset state
    idle(2);
    check("rst valid_out d5", 32'(if5.valid_out), 32'h0);
    check("rst frame_done d5", 32'(if5.frame_done), 32'h0);
    check("rst pxl_out d5", if5.pxl_out, 32'h0);
    check("rst valid_out d35", 32'(if35.valid_out), 32'h0);
    check("rst frame_done d35", 32'(if35.frame_done), 32'h0);
    check("rst pxl_out d35", if35.pxl_out, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    // Test 1: ramp, continuous
    clear_obs();
    for (int k = 0; k < 25; k++) send(0, f2b(k));
    idle(5);
    check("t1 strobes", 32'(strobes[0]), 32'd4);
    check("t1 frame_done count", 32'(fdones[0]), 32'd1);
    for (int i = 0; i < 4; i++) check($sformatf("t1 out%0d", i), (obs5.size() > i) ? obs5[i] : 32'hDEADBEEF, relu(t1[i]));

    // Test 2: all -1.0 except pixel 6 = -0.5
    clear_obs();
    for (int k = 0; k < 25; k++) send(0, (k == 6) ? 32'hBF000000 : 32'hBF800000);
    idle(5);
    check("t2 strobes", 32'(strobes[0]), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t2 out%0d", i), (obs5.size() > i) ? obs5[i] : 32'hDEADBEEF,
            relu((i == 0) ? 32'hBF000000 : 32'hBF800000));

    // Test 3: ramp with valid_in low every other cycle
    clear_obs();
    for (int k = 0; k < 25; k++) begin
      send(0, f2b(k));
      idle(1);
    end
    idle(5);
    check("t3 strobes", 32'(strobes[0]), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("t3 out%0d", i), (obs5.size() > i) ? obs5[i] : 32'hDEADBEEF, t1[i]);

    // Test 4: reset after pixel 13, then a full frame
    clear_obs();
    for (int k = 0; k < 14; k++) send(0, f2b(k));
    @(negedge clk);
    if5.valid_in = 1'b0;
    reset = 1'b1;
    q5.delete();
    q35.delete();
    mr = '{0, 0};
    mc = '{0, 0};
    @(negedge clk);
    check("t4 rst valid_out", 32'(if5.valid_out), 32'h0);
    check("t4 rst pxl_out", if5.pxl_out, 32'h0);
    reset = 1'b0;
    idle(2);
    check("t4 no strobe across reset", 32'(strobes[0]), 32'd0);
    for (int k = 0; k < 25; k++) send(0, f2b(k));
    idle(5);
    check("t4 strobes", 32'(strobes[0]), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("t4 out%0d", i), (obs5.size() > i) ? obs5[i] : 32'hDEADBEEF, t1[i]);

    // Test 5: D=35, two back-to-back ramp frames
    clear_obs();
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 1225; k++) send(1, f2b(k));
    idle(5);
    check("t5 strobes", 32'(strobes[1]), 32'd578);
    check("t5 frame_done count", 32'(fdones[1]), 32'd2);
    check("t5 first f0", (obs35.size() > 0) ? obs35[0] : 32'hDEADBEEF, 32'h42900000);
    check("t5 first f1", (obs35.size() > 289) ? obs35[289] : 32'hDEADBEEF, 32'h42900000);

    // Test 6: +0/-0 only, ties keep the first-arriving zero
    clear_obs();
    z00 = 32'h0;
    for (int k = 0; k < 25; k++) begin
      px = ($urandom_range(0, 1) == 1) ? 32'h80000000 : 32'h00000000;
      if (k == 0) z00 = px;
      send(0, px);
    end
    idle(5);
    check("t6 first zero", (obs5.size() > 0) ? obs5[0] : 32'hDEADBEEF, relu(z00));

    // Test 7: random bit patterns with random gaps, both sizes
    clear_obs();
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < 25; k++) begin
        send(0, $urandom);
        idle($urandom_range(0, 2));
      end
    for (int k = 0; k < 1225; k++) begin
      px = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
      send(1, px);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(5);
    check("t7 strobes d5", 32'(strobes[0]), 32'd16);
    check("t7 strobes d35", 32'(strobes[1]), 32'd289);
    check("t7 frame_done d5", 32'(fdones[0]), 32'd4);

    check("end queue d5 empty", 32'(q5.size()), 32'd0);
    check("end queue d35 empty", 32'(q35.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
